// File: rtl/fitbit_display_driver.sv
// Pedometer display back end: iterative binary-to-BCD conversion feeding a
// time-multiplexed, leading-zero-blanked 4-digit common-anode display.
module fitbit_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        frac_mode,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        dp,
  output logic        busy
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Values above 9999 saturate so the result always fits four digits and 14 bits.
  function automatic logic [13:0] clamp_bin(input logic [15:0] v);
    logic [13:0] r;
    if (v > 16'd9999) begin
      r = 14'd9999;
    end else begin
      r = v[13:0];
    end
    return r;
  endfunction

  function automatic logic [29:0] dabble_step(input logic [15:0] bcd, input logic [13:0] bin);
    logic [15:0] adj;
    adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (adj[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
      end else begin
        adj[4*n +: 4] = adj[4*n +: 4];
      end
    end
    return {adj[14:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  logic [3:0]    iter_r;
  logic [13:0]   bin_r;
  logic [15:0]   bcd_r;
  logic [29:0]   step_s;
  logic [15:0]   cap_val_r;
  logic          cap_frac_r;
  logic [15:0]   last_val_r;
  logic          last_frac_r;
  logic          valid_r;
  logic          pair_changed_s;
  logic [15:0]   disp_bcd_r;
  logic          disp_frac_r;
  logic [CW-1:0] refresh_r;
  logic [1:0]    idx_r;
  logic [3:0]    zero_s;
  logic [3:0]    blank_s;
  logic [3:0]    nib_s;
  logic          blank_sel_s;
  logic [3:0]    anode_r;
  logic [6:0]    segment_r;
  logic          dp_r;
  logic          busy_r;

  assign pair_changed_s = !valid_r || (value != last_val_r) || (frac_mode != last_frac_r);
  assign step_s         = dabble_step(bcd_r, bin_r);

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pair_changed_s) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD:  state_next_s = ST_SHIFT;
      ST_SHIFT: begin
        if (iter_r == 4'd13) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Conversion datapath; the display register only changes in DONE, so it never shows a partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_r      <= 4'd0;
      bin_r       <= 14'd0;
      bcd_r       <= 16'd0;
      cap_val_r   <= 16'd0;
      cap_frac_r  <= 1'b0;
      last_val_r  <= 16'd0;
      last_frac_r <= 1'b0;
      valid_r     <= 1'b0;
      disp_bcd_r  <= 16'd0;
      disp_frac_r <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          bin_r      <= clamp_bin(value);
          bcd_r      <= 16'd0;
          iter_r     <= 4'd0;
          cap_val_r  <= value;
          cap_frac_r <= frac_mode;
        end
        ST_SHIFT: begin
          bcd_r  <= step_s[29:14];
          bin_r  <= step_s[13:0];
          iter_r <= iter_r + 4'd1;
        end
        ST_DONE: begin
          disp_bcd_r  <= bcd_r;
          disp_frac_r <= cap_frac_r;
          last_val_r  <= cap_val_r;
          last_frac_r <= cap_frac_r;
          valid_r     <= 1'b1;
        end
        default: begin
          iter_r <= iter_r;
        end
      endcase
    end
  end

  // Refresh divider and digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_r <= '0;
      idx_r     <= 2'd0;
    end else if (refresh_r == CW'(REFRESH_DIV - 1)) begin
      refresh_r <= '0;
      idx_r     <= idx_r + 2'd1;
    end else begin
      refresh_r <= refresh_r + CW'(1);
    end
  end

  // A digit is blank when it and all higher digits are zero; frac mode keeps the "0." digit.
  assign zero_s[0] = (disp_bcd_r[3:0]   == 4'd0);
  assign zero_s[1] = (disp_bcd_r[7:4]   == 4'd0);
  assign zero_s[2] = (disp_bcd_r[11:8]  == 4'd0);
  assign zero_s[3] = (disp_bcd_r[15:12] == 4'd0);
  assign blank_s = {zero_s[3],
                    zero_s[3] & zero_s[2],
                    zero_s[3] & zero_s[2] & zero_s[1] & ~disp_frac_r,
                    1'b0};

  // Digit selection for the active index.
  always_comb begin
    nib_s       = disp_bcd_r[3:0];
    blank_sel_s = 1'b0;
    case (idx_r)
      2'd0: begin nib_s = disp_bcd_r[3:0];   blank_sel_s = blank_s[0]; end
      2'd1: begin nib_s = disp_bcd_r[7:4];   blank_sel_s = blank_s[1]; end
      2'd2: begin nib_s = disp_bcd_r[11:8];  blank_sel_s = blank_s[2]; end
      2'd3: begin nib_s = disp_bcd_r[15:12]; blank_sel_s = blank_s[3]; end
      default: begin nib_s = 4'd0; blank_sel_s = 1'b1; end
    endcase
  end

  // Registered display outputs and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_r   <= 4'b1111;
      segment_r <= 7'b1111111;
      dp_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      anode_r   <= ~(4'b0001 << idx_r);
      segment_r <= blank_sel_s ? 7'b1111111 : seg_encode(nib_s);
      dp_r      <= ~((idx_r == 2'd1) && disp_frac_r);
      busy_r    <= (state_next_s != ST_IDLE);
    end
  end

  assign anode   = anode_r;
  assign segment = segment_r;
  assign dp      = dp_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_fitbit_display_driver.sv
// Randomized self-checking bench for fitbit_display_driver against a
// decimal-arithmetic model with a fixed 16-cycle conversion latency.
module tb_fitbit_display_driver;

  localparam int DIV  = 4;
  localparam int DIV2 = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic        frac_mode = 1'b0;
  logic [3:0]  anode, anode2;
  logic [6:0]  segment, segment2;
  logic        dp, dp2, busy, busy2;

  int checks = 0;
  int errors = 0;

  fitbit_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .value(value), .frac_mode(frac_mode),
    .anode(anode), .segment(segment), .dp(dp), .busy(busy));

  fitbit_display_driver #(.REFRESH_DIV(DIV2)) dut2 (
    .clk(clk), .reset(reset), .value(value), .frac_mode(frac_mode),
    .anode(anode2), .segment(segment2), .dp(dp2), .busy(busy2));

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] model_seg(input int val, input bit frac, input int k);
    int d = (val / pow10(k)) % 10;
    if (k != 0 && val < pow10(k) && !(k == 1 && frac)) return 7'b1111111;
    return seg_tab[d];
  endfunction

  // Behavioural model: m_cnt counts cycles since a conversion started (0 = idle, 16 = result lands).
  int   m_cnt, m_disp_val, m_cap_val, m_last_val, m_refresh, m_idx;
  bit   m_disp_frac, m_cap_frac, m_last_frac, m_valid;
  bit   m_ready = 1'b0;
  logic [3:0] exp_anode;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_busy;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0; m_valid <= 1'b0; m_disp_val <= 0; m_disp_frac <= 1'b0;
      m_refresh <= 0; m_idx <= 0; m_ready <= 1'b1;
      exp_anode <= 4'b1111; exp_seg <= 7'b1111111; exp_dp <= 1'b1; exp_busy <= 1'b0;
    end else begin
      exp_anode <= 4'b1111 ^ (4'b0001 << m_idx);
      exp_seg   <= model_seg(m_disp_val, m_disp_frac, m_idx);
      exp_dp    <= !(m_idx == 1 && m_disp_frac);
      if (m_refresh == DIV - 1) begin
        m_refresh <= 0;
        m_idx     <= (m_idx + 1) % 4;
      end else begin
        m_refresh <= m_refresh + 1;
      end
      if (m_cnt == 0) begin
        if (!m_valid || int'(value) != m_last_val || frac_mode != m_last_frac) m_cnt <= 1;
      end else if (m_cnt == 1) begin
        m_cap_val <= int'(value); m_cap_frac <= frac_mode; m_cnt <= 2;
      end else if (m_cnt == 16) begin
        m_disp_val  <= (m_cap_val > 9999) ? 9999 : m_cap_val;
        m_disp_frac <= m_cap_frac;
        m_last_val  <= m_cap_val;
        m_last_frac <= m_cap_frac;
        m_valid     <= 1'b1;
        m_cnt       <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      exp_busy <= (m_cnt == 0) ? (!m_valid || int'(value) != m_last_val || frac_mode != m_last_frac)
                               : (m_cnt != 16);
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("anode", anode, exp_anode);
      chk("segment", segment, exp_seg);
      chk("dp", dp, exp_dp);
      chk("busy", busy, exp_busy);
    end
  end

  // Cadence of the slow-refresh instance: one active anode, each lit for exactly DIV2 cycles.
  logic       r_q;
  int         run2 = 0;
  logic [3:0] prev2 = 4'b1111;
  always @(posedge clk) r_q <= reset;
  always @(negedge clk) begin
    if (r_q === 1'b1) begin
      chk("anode2_reset", anode2, 4'b1111);
      run2  = 0;
      prev2 = 4'b1111;
    end else if (r_q === 1'b0) begin
      chk("anode2_onehot", 16'($countones(~anode2)), 16'd1);
      chk("busy2", busy2, exp_busy);
      chk("dp2", dp2 | (anode2 == 4'b1101), 1'b1);
      if (anode2 == 4'b1110) chk("seg2_digit0_lit", segment2 == 7'b1111111, 1'b0);
      if (anode2 == prev2) begin
        run2++;
      end else begin
        if (prev2 != 4'b1111) chk("anode2_run", 16'(run2), 16'(DIV2));
        prev2 = anode2;
        run2  = 1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (m_cnt == 0 && m_valid && m_last_val == int'(value) && m_last_frac == frac_mode && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy=%b still converting, expected idle within 80 cycles", busy);
    end
    @(negedge clk);
  endtask

  task automatic sweep(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0, input logic dp1);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      case (anode)
        4'b1110: begin chk("sweep_d0", segment, s0); chk("sweep_dp0", dp, 1'b1); end
        4'b1101: begin chk("sweep_d1", segment, s1); chk("sweep_dp1", dp, dp1);  end
        4'b1011: begin chk("sweep_d2", segment, s2); chk("sweep_dp2", dp, 1'b1); end
        4'b0111: begin chk("sweep_d3", segment, s3); chk("sweep_dp3", dp, 1'b1); end
        default: chk("sweep_anode", anode, 4'b1110);
      endcase
    end
  endtask

  localparam logic [6:0] BL = 7'b1111111;

  initial begin
    int bcount;
    bit ok;
    // Reset values, first post-reset digit, conversion length, integer sweep.
    reset = 1'b1; value = 16'd1234; frac_mode = 1'b0;
    cycles(3);
    chk("rst_anode", anode, 4'b1111); chk("rst_seg", segment, BL);
    chk("rst_dp", dp, 1'b1);          chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_anode", anode, 4'b1110); chk("first_seg", segment, 7'b1000000);
    bcount = int'(busy);
    for (int i = 0; i < 30; i++) begin @(negedge clk); bcount += int'(busy); end
    chk("busy_len", 16'(bcount), 16'd16);
    wait_idle();
    sweep(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 1'b1);

    // Blanking and decimal point.
    value = 16'd5; frac_mode = 1'b1;
    wait_idle();
    sweep(BL, BL, 7'b1000000, 7'b0010010, 1'b0);
    frac_mode = 1'b0;
    wait_idle();
    sweep(BL, BL, BL, 7'b0010010, 1'b1);

    // Input change during SHIFT: 42 lands first, then 77.
    value = 16'd42;
    cycles(7);
    value = 16'd77;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_disp_val == 42 && m_cnt == 0) begin ok = 1'b1; break; end
    end
    chk("mid_change_first", 16'(ok), 16'd1);
    sweep(BL, BL, 7'b0011001, 7'b0100100, 1'b1);
    wait_idle();
    sweep(BL, BL, 7'b1111000, 7'b1111000, 1'b1);

    // Clamp and all-zero.
    value = 16'hFFFF;
    wait_idle();
    sweep(7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 1'b1);
    value = 16'd0;
    wait_idle();
    sweep(BL, BL, BL, 7'b1000000, 1'b1);

    // Reset in the middle of a conversion.
    value = 16'd8888;
    cycles(6);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);  chk("midrst_anode", anode, 4'b1111);
    chk("midrst_seg", segment, BL);  chk("midrst_dp", dp, 1'b1);
    cycles(1);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_busy", busy, 1'b1);
    wait_idle();
    sweep(7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1);

    // Randomized traffic, including changes mid-conversion and occasional resets.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: value = 16'($urandom_range(0, 99));
        1: value = 16'($urandom_range(0, 9999));
        2: value = 16'($urandom_range(9990, 10010));
        default: value = 16'($urandom);
      endcase
      frac_mode = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 30));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        cycles($urandom_range(1, 2));
        reset = 1'b0;
      end
    end

    // Long quiet stretch for the slow-refresh cadence.
    value = 16'($urandom_range(0, 9999));
    cycles(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fitbit_display_driver.md
# fitbit_display_driver

Sequential seven-segment back end for the pedometer display path. It takes the 16-bit binary value and the fractional-mode flag selected by the mode-cycling master. It converts the value to four BCD digits with an iterative shift-add-3 engine, then time-multiplexes the digits onto the 4-digit common-anode display with leading-zero blanking and decimal-point insertion. The previously converted value stays on the display until a new conversion completes, so the display never flickers mid-update.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `value`  in  16  unsigned binary quantity to display.
- `frac_mode`  in  1  1 = value is in tenths and is shown as XXX.Y; 0 = integer.
- `anode`  out  4  active-low one-hot digit enable; `anode[0]` is the rightmost digit.
- `segment`  out  7  active-low `{g,f,e,d,c,b,a}`.
- `dp`  out  1  active-low decimal point.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- **Clamp.** Any value > 9999 is treated as 9999 before conversion. This applies in both modes.
- **Conversion FSM states:** IDLE, LOAD, SHIFT, DONE.
  - **IDLE:** if `{value, frac_mode}` ≠ the last converted pair, or the valid flag is clear, go to LOAD. Otherwise stay in IDLE.
  - **LOAD:** capture the clamped value and `frac_mode` into working registers, clear the 16-bit BCD accumulator, and set iteration count = 0.
  - **SHIFT:** runs exactly 14 iterations (9999 < 2^14), using bits [13:0] MSB first. Each iteration:
    - add 3 to every BCD nibble ≥ 5;
    - then shift `{bcd, bin}` left by 1.
  - **DONE:** copy the BCD result and the captured `frac_mode` into the display register, record the converted pair, set the valid flag, and return to IDLE.
- **busy** = 1 in LOAD, SHIFT and DONE; 0 in IDLE.
- **Input changes during a conversion** are ignored until the FSM is back in IDLE, then picked up by the IDLE compare. The final input value is never lost.
- **Digit mux.**
  - A refresh counter runs 0..REFRESH_DIV-1. On wrap, the 2-bit digit index increments 0→1→2→3→0.
  - The index selects a nibble from the display register.
- **Blanking.**
  - Digit k (k = 3..1) is blank when it is zero and every higher digit is zero.
  - In frac mode, digit 1 is never blank.
  - Digit 0 is never blank.
- **dp** = 0 only when the index is 1 and the display register's frac flag is 1; otherwise dp = 1.
- **Segment encoding:**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
  - nibble > 9 (unreachable) = blank
- **Reset (any state, including mid-conversion):**
  - abort the conversion; FSM returns to IDLE;
  - display register cleared (digits 0, frac 0); valid flag cleared; refresh counter = 0; index = 0.
  - After reset deasserts, the current input is converted automatically.

## Timing
- All outputs are registered, and the reset values are:
  - `anode` = 1111, `segment` = 1111111, `dp` = 1, `busy` = 0.
- The first clk edge after reset deasserts drives digit 0 of the cleared register: `anode` = 1110, `segment` = 1000000.
- Conversion latency: 16 cycles from entering LOAD to the display register updating (LOAD 1 + SHIFT 14 + DONE 1).
  - An input change seen by IDLE at edge N updates the display register at edge N+17.
  - The new digits reach `segment` on the following edge for the currently selected index.
- Output registers update every cycle from the current index and display register.
- The index advances when the refresh counter wraps, so each digit is lit for exactly REFRESH_DIV cycles.
- The index wraps 3→0 with no gap cycle; exactly one anode bit is low at all times after the first post-reset edge.

## Test plan
- **Integer conversion.** REFRESH_DIV=4, `value`=1234, `frac_mode`=0 → `busy` high for 16 cycles. Then the digit sweep shows anode 1110/1101/1011/0111 with segment 0011001/0110000/0100100/1111001. dp stays 1.
- **Blanking and decimal point.** `value`=5, `frac_mode`=1 → digits 3, 2 blank (1111111); digit 1 = "0" with dp = 0; digit 0 = "5". With `frac_mode`=0 the same value shows digits 3..1 blank and digit 0 = "5".
- **Clamp.** `value`=16'hFFFF → display 9999 on all four digits. `value`=0, `frac_mode`=0 → only digit 0 lit with "0".
- **Input change mid-conversion.** Change `value` 42→77 at SHIFT iteration 5 → the display register first shows 42. A second conversion follows immediately, and the display shows 77 seventeen cycles after IDLE is re-entered.
- **Reset mid-conversion.** Assert `reset` during SHIFT with `value`=8888 held → outputs go to the reset values and `busy` = 0. After release, `busy` rises on the next edge, and 8888 appears after 16 cycles of conversion.
- **Refresh cadence.** REFRESH_DIV=100 → each anode is low for exactly 100 consecutive cycles, giving a 400-cycle period. There is never zero or more than one active anode.
